// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, functs, ALU ops,
// operand/destination/write-back selects and the decoded control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Codes 11..31 are unused and yield 0; ALU_NONE is the one the decoder
    // picks for illegal instructions.
    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_NONE = 5'd31
    } alu_op_e;

    typedef enum logic [1:0] {
        ASEL_RS    = 2'd0,
        ASEL_SHAMT = 2'd1,
        ASEL_16    = 2'd2
    } asel_e;

    typedef enum logic {
        BSEL_RT  = 1'b0,
        BSEL_IMM = 1'b1
    } bsel_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MEM = 2'd1,
        M2R_PC4 = 2'd2
    } m2r_e;

    typedef enum logic [1:0] {
        RDST_RT = 2'd0,
        RDST_RD = 2'd1,
        RDST_RA = 2'd2
    } rdst_e;

    typedef struct packed {
        alu_op_e alu_op;
        asel_e   a_sel;
        bsel_e   b_sel;
        logic    ext;
        rdst_e   reg_dst;
        m2r_e    mem2reg;
        logic    reg_wr;
        logic    mem_wr;
        logic    br_eq;
        logic    br_ne;
        logic    jump;
        logic    jump_reg;
        logic    illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: 32-bit MIPS ALU with zero and signed-overflow flags.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module alu_core
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] y,
    output logic        zero,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        y   = 32'd0;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = sum;
                ovf = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                y   = diff;
                ovf = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            // Shifts move B by the low five bits of A.
            ALU_SLL:  y = b << a[4:0];
            ALU_SRL:  y = b >> a[4:0];
            ALU_SRA:  y = $signed(b) >>> a[4:0];
            default:  y = 32'd0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/mips_decode_exec.sv
// Purpose: MIPS main decoder, immediate extender and ALU operand muxing, registered.
// Latency: 1 cycle from instr/rs_data/rt_data to every output.
// Backpressure: none; a new instruction is accepted every cycle.
module mips_decode_exec
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        ovf,
    output logic [31:0] ext_imm,
    output logic [4:0]  wr_addr,
    output logic [1:0]  mem2reg,
    output logic        reg_wr,
    output logic        mem_wr,
    output logic        br_eq,
    output logic        br_ne,
    output logic        jump,
    output logic        jump_reg,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    ctrl_t       ctrl;
    logic [31:0] ext_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        alu_ovf;
    logic [4:0]  dst;
    logic        unused_rs_field;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign shamt  = instr[10:6];
    assign imm    = instr[15:0];

    // The rs field only addresses the register file upstream.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        ctrl     = '0;
        ctrl.ext = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst = RDST_RD;
                ctrl.reg_wr  = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLTU: ctrl.alu_op = ALU_SLTU;
                    FN_SLL: begin
                        ctrl.alu_op = ALU_SLL;
                        ctrl.a_sel  = ASEL_SHAMT;
                    end
                    FN_SRL: begin
                        ctrl.alu_op = ALU_SRL;
                        ctrl.a_sel  = ASEL_SHAMT;
                    end
                    FN_SRA: begin
                        ctrl.alu_op = ALU_SRA;
                        ctrl.a_sel  = ASEL_SHAMT;
                    end
                    FN_SLLV: ctrl.alu_op = ALU_SLL;
                    FN_SRLV: ctrl.alu_op = ALU_SRL;
                    FN_SRAV: ctrl.alu_op = ALU_SRA;
                    FN_JR: begin
                        ctrl.reg_wr   = 1'b0;
                        ctrl.jump_reg = 1'b1;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.b_sel  = BSEL_IMM;
                ctrl.reg_wr = 1'b1;
                case (opcode)
                    OP_SLTI:  ctrl.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl.alu_op = ALU_SLTU;
                    OP_ANDI: begin
                        ctrl.alu_op = ALU_AND;
                        ctrl.ext    = 1'b0;
                    end
                    OP_ORI: begin
                        ctrl.alu_op = ALU_OR;
                        ctrl.ext    = 1'b0;
                    end
                    OP_XORI: begin
                        ctrl.alu_op = ALU_XOR;
                        ctrl.ext    = 1'b0;
                    end
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_LUI: begin
                ctrl.alu_op = ALU_SLL;
                ctrl.a_sel  = ASEL_16;
                ctrl.b_sel  = BSEL_IMM;
                ctrl.ext    = 1'b0;
                ctrl.reg_wr = 1'b1;
            end
            OP_LW: begin
                ctrl.b_sel   = BSEL_IMM;
                ctrl.mem2reg = M2R_MEM;
                ctrl.reg_wr  = 1'b1;
            end
            OP_SW: begin
                ctrl.b_sel  = BSEL_IMM;
                ctrl.mem_wr = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.br_eq  = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.br_ne  = 1'b1;
            end
            OP_J:   ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump    = 1'b1;
                ctrl.reg_dst = RDST_RA;
                ctrl.mem2reg = M2R_PC4;
                ctrl.reg_wr  = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        // Illegal instructions must not disturb architectural state.
        if (ctrl.illegal) begin
            ctrl         = '0;
            ctrl.ext     = 1'b1;
            ctrl.alu_op  = ALU_NONE;
            ctrl.illegal = 1'b1;
        end
    end

    assign ext_val = ctrl.ext ? {{16{imm[15]}}, imm} : {16'd0, imm};

    always_comb begin
        case (ctrl.a_sel)
            ASEL_SHAMT: alu_a = {27'd0, shamt};
            ASEL_16:    alu_a = 32'd16;
            default:    alu_a = rs_data;
        endcase
    end

    assign alu_b = (ctrl.b_sel == BSEL_IMM) ? ext_val : rt_data;

    always_comb begin
        case (ctrl.reg_dst)
            RDST_RD: dst = instr[15:11];
            RDST_RA: dst = 5'd31;
            default: dst = instr[20:16];
        endcase
    end

    alu_core u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (ctrl.alu_op),
        .y    (alu_y),
        .zero (alu_zero),
        .ovf  (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            alu_out   <= 32'd0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            ext_imm   <= 32'd0;
            wr_addr   <= 5'd0;
            mem2reg   <= 2'd0;
            reg_wr    <= 1'b0;
            mem_wr    <= 1'b0;
            br_eq     <= 1'b0;
            br_ne     <= 1'b0;
            jump      <= 1'b0;
            jump_reg  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            alu_out   <= alu_y;
            zero      <= alu_zero;
            ovf       <= alu_ovf;
            ext_imm   <= ext_val;
            wr_addr   <= dst;
            mem2reg   <= ctrl.mem2reg;
            illegal   <= ctrl.illegal;
            // Bubbles still carry data but must never commit anything.
            reg_wr    <= in_valid & ctrl.reg_wr;
            mem_wr    <= in_valid & ctrl.mem_wr;
            br_eq     <= in_valid & ctrl.br_eq;
            br_ne     <= in_valid & ctrl.br_ne;
            jump      <= in_valid & ctrl.jump;
            jump_reg  <= in_valid & ctrl.jump_reg;
        end
    end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Bench for mips_decode_exec: directed cases plus random instructions checked
// against an instruction-level reference model.
module tb_mips_decode_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr, rs_data, rt_data;
    logic        out_valid, zero, ovf, reg_wr, mem_wr, br_eq, br_ne, jump, jump_reg, illegal;
    logic [31:0] alu_out, ext_imm;
    logic [4:0]  wr_addr;
    logic [1:0]  mem2reg;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] alu;
        logic        zero, ovf;
        logic [31:0] ext;
        logic [4:0]  wr;
        logic [1:0]  m2r;
        logic        reg_wr, mem_wr, beq, bne, j, jr, ill;
        logic        chk_alu, chk_wr;
    } exp_t;

    logic [5:0] r_fns  [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
    logic [5:0] ij_ops [16] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h01};

    always #5 clk = ~clk;

    mips_decode_exec dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
        .alu_out(alu_out), .zero(zero), .ovf(ovf), .ext_imm(ext_imm),
        .wr_addr(wr_addr), .mem2reg(mem2reg), .reg_wr(reg_wr), .mem_wr(mem_wr),
        .br_eq(br_eq), .br_ne(br_ne), .jump(jump), .jump_reg(jump_reg),
        .illegal(illegal)
    );

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // {overflow, result} from true signed arithmetic on 64-bit integers.
    function automatic logic [32:0] add_ref(input logic [31:0] a, input logic [31:0] b);
        longint s = longint'($signed(a)) + longint'($signed(b));
        return {(s > 64'sd2147483647) || (s < -64'sd2147483648), a + b};
    endfunction

    function automatic logic [32:0] sub_ref(input logic [31:0] a, input logic [31:0] b);
        longint s = longint'($signed(a)) - longint'($signed(b));
        return {(s > 64'sd2147483647) || (s < -64'sd2147483648), a - b};
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                   input logic [31:0] rt, input logic vld);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] sx, zx;
        int          sh;
        op = ins[31:26];
        fn = ins[5:0];
        sh = int'(ins[10:6]);
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'd0, ins[15:0]};
        e = '{default: '0};
        e.chk_alu = 1'b1;
        e.ext = (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) ? zx : sx;
        case (op)
            6'h00: begin
                e.wr = ins[15:11]; e.chk_wr = 1'b1; e.reg_wr = 1'b1;
                case (fn)
                    6'h20, 6'h21: {e.ovf, e.alu} = add_ref(rs, rt);
                    6'h22, 6'h23: {e.ovf, e.alu} = sub_ref(rs, rt);
                    6'h24: e.alu = rs & rt;
                    6'h25: e.alu = rs | rt;
                    6'h26: e.alu = rs ^ rt;
                    6'h27: e.alu = ~(rs | rt);
                    6'h2A: e.alu = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                    6'h2B: e.alu = (rs < rt) ? 32'd1 : 32'd0;
                    6'h00: e.alu = rt << sh;
                    6'h02: e.alu = rt >> sh;
                    6'h03: e.alu = $signed(rt) >>> sh;
                    6'h04: e.alu = rt << (rs % 32);
                    6'h06: e.alu = rt >> (rs % 32);
                    6'h07: e.alu = $signed(rt) >>> (rs % 32);
                    6'h08: begin e.jr = 1'b1; e.reg_wr = 1'b0; e.chk_alu = 1'b0; e.chk_wr = 1'b0; end
                    default: e.ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: {e.ovf, e.alu} = add_ref(rs, sx);
            6'h0A: e.alu = ($signed(rs) < $signed(sx)) ? 32'd1 : 32'd0;
            6'h0B: e.alu = (rs < sx) ? 32'd1 : 32'd0;
            6'h0C: e.alu = rs & zx;
            6'h0D: e.alu = rs | zx;
            6'h0E: e.alu = rs ^ zx;
            6'h0F: e.alu = zx * 32'd65536;
            6'h23: begin {e.ovf, e.alu} = add_ref(rs, sx); e.m2r = 2'd1; end
            6'h2B: begin {e.ovf, e.alu} = add_ref(rs, sx); e.mem_wr = 1'b1; end
            6'h04: begin {e.ovf, e.alu} = sub_ref(rs, rt); e.beq = 1'b1; end
            6'h05: begin {e.ovf, e.alu} = sub_ref(rs, rt); e.bne = 1'b1; end
            6'h02: begin e.j = 1'b1; e.chk_alu = 1'b0; end
            6'h03: begin e.j = 1'b1; e.chk_alu = 1'b0; e.wr = 5'd31; e.chk_wr = 1'b1;
                         e.m2r = 2'd2; e.reg_wr = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23}) begin
            e.wr = ins[20:16]; e.chk_wr = 1'b1; e.reg_wr = 1'b1;
        end
        if (e.ill) begin
            e.alu = 32'd0; e.ovf = 1'b0; e.chk_wr = 1'b0; e.m2r = 2'd0;
            {e.reg_wr, e.mem_wr, e.beq, e.bne, e.j, e.jr} = '0;
        end
        e.zero = (e.alu == 32'd0);
        if (!vld) {e.reg_wr, e.mem_wr, e.beq, e.bne, e.j, e.jr} = '0;
        return e;
    endfunction

    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic v);
        @(negedge clk);
        instr = i; rs_data = a; rt_data = b; in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        apply(rtype(1, 2, 3, 0, 'h21), 32'd5, 32'd7, 1'b1);
        n_tests++;
        if ({out_valid, alu_out, zero, ovf, ext_imm, wr_addr, mem2reg, reg_wr, mem_wr,
             br_eq, br_ne, jump, jump_reg, illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: alu=%h wr=%0d reg_wr=%b vld=%b, all must be 0",
                     alu_out, wr_addr, reg_wr, out_valid);
        end
        rst = 1'b1;
        apply(rtype(1, 2, 3, 0, 'h21), 32'd5, 32'd7, 1'b1);
        n_tests++;
        if ({out_valid, alu_out, wr_addr, reg_wr} !== {1'b1, 32'd12, 5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL addu_after_reset: vld=%b alu=%0d wr=%0d reg_wr=%b, want 1 12 3 1",
                     out_valid, alu_out, wr_addr, reg_wr);
        end
        rst = 1'b0;
        apply(itype('h2B, 1, 2, 4), 32'd5, 32'd7, 1'b1);
        n_tests++;
        if ({out_valid, alu_out, mem_wr} !== '0) begin
            n_fail++;
            $display("FAIL midstream_reset: vld=%b alu=%h mem_wr=%b, want 0 0 0",
                     out_valid, alu_out, mem_wr);
        end
        rst = 1'b1;
    endtask

    task automatic test_overflow();
        apply(rtype(1, 2, 3, 0, 'h20), 32'h7FFFFFFF, 32'd1, 1'b1);
        n_tests++;
        if ({alu_out, ovf} !== {32'h80000000, 1'b1}) begin
            n_fail++;
            $display("FAIL add_ovf: alu=%h ovf=%b, want 80000000 1", alu_out, ovf);
        end
        apply(rtype(1, 2, 3, 0, 'h22), 32'd0, 32'd1, 1'b1);
        n_tests++;
        if ({alu_out, ovf} !== {32'hFFFFFFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_no_ovf: alu=%h ovf=%b, want ffffffff 0", alu_out, ovf);
        end
    endtask

    task automatic test_immediates();
        apply(itype('h08, 1, 4, 'hFFFF), 32'd10, 32'd0, 1'b1);
        n_tests++;
        if ({alu_out, wr_addr} !== {32'd9, 5'd4}) begin
            n_fail++;
            $display("FAIL addi_neg: alu=%h wr=%0d, want 9 4", alu_out, wr_addr);
        end
        apply(itype('h0D, 1, 4, 'hFFFF), 32'd0, 32'd0, 1'b1);
        n_tests++;
        if (alu_out !== 32'h0000FFFF) begin
            n_fail++;
            $display("FAIL ori_zext: alu=%h, want 0000ffff", alu_out);
        end
        apply(itype('h0F, 0, 4, 'h1234), 32'hDEAD, 32'd0, 1'b1);
        n_tests++;
        if ({alu_out, ext_imm} !== {32'h12340000, 32'h00001234}) begin
            n_fail++;
            $display("FAIL lui: alu=%h ext=%h, want 12340000 00001234", alu_out, ext_imm);
        end
    endtask

    task automatic test_shifts();
        apply(rtype(0, 2, 3, 4, 'h03), 32'd0, 32'h80000000, 1'b1);
        n_tests++;
        if (alu_out !== 32'hF8000000) begin
            n_fail++;
            $display("FAIL sra: alu=%h, want f8000000", alu_out);
        end
        apply(rtype(1, 2, 3, 0, 'h06), 32'd36, 32'h100, 1'b1);
        n_tests++;
        if (alu_out !== 32'h10) begin
            n_fail++;
            $display("FAIL srlv: alu=%h, want 00000010", alu_out);
        end
    endtask

    task automatic test_compare();
        apply(rtype(1, 2, 3, 0, 'h2A), 32'hFFFFFFFF, 32'd1, 1'b1);
        n_tests++;
        if (alu_out !== 32'd1) begin
            n_fail++;
            $display("FAIL slt: alu=%h, want 1", alu_out);
        end
        apply(rtype(1, 2, 3, 0, 'h2B), 32'hFFFFFFFF, 32'd1, 1'b1);
        n_tests++;
        if (alu_out !== 32'd0) begin
            n_fail++;
            $display("FAIL sltu: alu=%h, want 0", alu_out);
        end
        apply(itype('h04, 1, 2, 3), 32'd9, 32'd9, 1'b1);
        n_tests++;
        if ({zero, br_eq, br_ne, reg_wr, mem_wr} !== 5'b11000) begin
            n_fail++;
            $display("FAIL beq: zero=%b br_eq=%b br_ne=%b reg_wr=%b mem_wr=%b, want 1 1 0 0 0",
                     zero, br_eq, br_ne, reg_wr, mem_wr);
        end
    endtask

    task automatic test_control();
        apply(itype('h23, 1, 6, 8), 32'd100, 32'd0, 1'b1);
        n_tests++;
        if ({mem2reg, reg_wr, wr_addr, alu_out} !== {2'd1, 1'b1, 5'd6, 32'd108}) begin
            n_fail++;
            $display("FAIL lw: m2r=%0d reg_wr=%b wr=%0d alu=%0d, want 1 1 6 108",
                     mem2reg, reg_wr, wr_addr, alu_out);
        end
        apply(itype('h2B, 1, 6, 'hFFFC), 32'd100, 32'd0, 1'b1);
        n_tests++;
        if ({mem_wr, reg_wr, alu_out} !== {1'b1, 1'b0, 32'd96}) begin
            n_fail++;
            $display("FAIL sw: mem_wr=%b reg_wr=%b alu=%0d, want 1 0 96", mem_wr, reg_wr, alu_out);
        end
        apply({6'h03, 26'h123456}, 32'd0, 32'd0, 1'b1);
        n_tests++;
        if ({wr_addr, mem2reg, jump, reg_wr} !== {5'd31, 2'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL jal: wr=%0d m2r=%0d jump=%b reg_wr=%b, want 31 2 1 1",
                     wr_addr, mem2reg, jump, reg_wr);
        end
        apply(rtype(31, 0, 0, 0, 'h08), 32'h400, 32'd0, 1'b1);
        n_tests++;
        if ({jump_reg, jump, reg_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL jr: jump_reg=%b jump=%b reg_wr=%b, want 1 0 0", jump_reg, jump, reg_wr);
        end
        apply({6'h3F, 26'h2AAAAAA}, 32'd3, 32'd4, 1'b1);
        n_tests++;
        if ({illegal, alu_out, reg_wr, mem_wr, br_eq, br_ne, jump, jump_reg} !== {1'b1, 38'd0}) begin
            n_fail++;
            $display("FAIL illegal_op: ill=%b alu=%h enables=%b%b%b%b%b%b, want 1 0 000000",
                     illegal, alu_out, reg_wr, mem_wr, br_eq, br_ne, jump, jump_reg);
        end
        apply(rtype(1, 2, 3, 0, 'h21), 32'd5, 32'd7, 1'b0);
        n_tests++;
        if ({out_valid, reg_wr, alu_out} !== {1'b0, 1'b0, 32'd12}) begin
            n_fail++;
            $display("FAIL invalid_bubble: vld=%b reg_wr=%b alu=%0d, want 0 0 12",
                     out_valid, reg_wr, alu_out);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] i, a, b;
        logic        v;
        for (int n = 0; n < 600; n++) begin
            i = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin i[31:26] = 6'd0; i[5:0] = r_fns[$urandom_range(0, 17)]; end
                9: ;
                default: i[31:26] = ij_ops[$urandom_range(0, 15)];
            endcase
            a = pick_operand();
            b = ($urandom_range(0, 5) == 0) ? a : pick_operand();
            v = ($urandom_range(0, 7) != 0);
            e = model(i, a, b, v);
            apply(i, a, b, v);
            if (e.chk_alu) begin
                n_tests++;
                if ({alu_out, zero, ovf} !== {e.alu, e.zero, e.ovf}) begin
                    n_fail++;
                    $display("FAIL rand_alu[%0d] instr=%h: alu=%h z=%b o=%b, want %h %b %b",
                             n, i, alu_out, zero, ovf, e.alu, e.zero, e.ovf);
                end
            end
            n_tests++;
            if (ext_imm !== e.ext) begin
                n_fail++;
                $display("FAIL rand_ext[%0d] instr=%h: %h, want %h", n, i, ext_imm, e.ext);
            end
            if (e.chk_wr) begin
                n_tests++;
                if (wr_addr !== e.wr) begin
                    n_fail++;
                    $display("FAIL rand_wr_addr[%0d] instr=%h: %0d, want %0d", n, i, wr_addr, e.wr);
                end
            end
            n_tests++;
            if ({out_valid, mem2reg, reg_wr, mem_wr, br_eq, br_ne, jump, jump_reg} !==
                {v, e.m2r, e.reg_wr, e.mem_wr, e.beq, e.bne, e.j, e.jr}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d] instr=%h: %b_%b_%b%b%b%b%b%b, want %b_%b_%b%b%b%b%b%b",
                         n, i, out_valid, mem2reg, reg_wr, mem_wr, br_eq, br_ne, jump, jump_reg,
                         v, e.m2r, e.reg_wr, e.mem_wr, e.beq, e.bne, e.j, e.jr);
            end
            if (v) begin
                n_tests++;
                if (illegal !== e.ill) begin
                    n_fail++;
                    $display("FAIL rand_illegal[%0d] instr=%h: %b, want %b", n, i, illegal, e.ill);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
        test_reset();
        test_overflow();
        test_immediates();
        test_shifts();
        test_compare();
        test_control();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
